// File: rtl/sample_packer_pkg.sv
// Shared defaults and derived widths for the sample packer, its filter top and its bench.
package sample_packer_pkg;

    localparam int N_DEF     = 3;
    localparam int DSR_DEF   = 12;
    localparam int DEPTH_DEF = 19;
    localparam int NBLK      = 4;

    function automatic int word_w(input int n, input int dsr);
        return n * dsr;
    endfunction

    function automatic int addr_w(input int depth);
        return $clog2(NBLK * depth);
    endfunction

    // A one-sample word still needs a one-bit counter to keep the vector legal.
    function automatic int cnt_w(input int dsr);
        return (dsr > 1) ? $clog2(dsr) : 1;
    endfunction

    localparam int W_DEF  = word_w(N_DEF, DSR_DEF);
    localparam int AW_DEF = addr_w(DEPTH_DEF);

endpackage

// File: rtl/sample_packer_shift.sv
// Accumulates N-bit samples LSB-first into a DSR-sample word; word_o is the
// completed word (combinational) whenever word_valid_o is high.
module sample_shift
    import sample_packer_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int DSR = DSR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     sample_i,
    input  logic             valid_i,
    output logic [N*DSR-1:0] word_o,
    output logic             word_valid_o
);

    localparam int             CW   = cnt_w(DSR);
    localparam logic [CW-1:0]  LAST = CW'(DSR - 1);

    logic [N*DSR-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < DSR; k++) begin
            if (cnt_q == CW'(k)) begin
                acc_d[k*N +: N] = sample_i;
            end
        end
        cnt_d = cnt_q;
        if (valid_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign word_o       = acc_d;
    assign word_valid_o = valid_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Stale slots are always overwritten before reuse, so the data needs no reset.
    always_ff @(posedge clk) begin
        if (valid_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sample_packer.sv
// Packs samples into RAM words, tracks four-block ring occupancy and flags overflow.
// Optional SAMPLE_PACKER_OVF_CNT_EN adds a saturating 16-bit dropped-word counter.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter  int N     = N_DEF,
    parameter  int DSR   = DSR_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int W     = word_w(N, DSR),
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in,
    input  logic          in_valid,
    input  logic          blk_ack,
    output logic          sampleWrite,
    output logic [AW-1:0] sampleAddrIn,
    output logic [W-1:0]  sampleDataIn,
    output logic          blk_done,
    output logic [1:0]    blk_idx,
    output logic          ovf
`ifdef SAMPLE_PACKER_OVF_CNT_EN
    ,
    output logic [15:0]   ovf_cnt
`endif
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(NBLK * DEPTH - 1);

    logic [W-1:0]  word;
    logic          word_valid;

    logic          sampleWrite_q;
    logic [AW-1:0] sampleAddrIn_q;
    logic [W-1:0]  sampleDataIn_q;
    logic          blk_done_q;
    logic [1:0]    blk_idx_q;
    logic          ovf_q;
    logic [2:0]    occ_q, occ_d;

    logic          release_blk;
    logic          full;
    logic          write_go;
    logic          drop;
    logic [AW-1:0] addr_cur;
    logic          blk_end;
    logic [1:0]    blk_end_idx;

    sample_shift #(
        .N   (N),
        .DSR (DSR)
    ) u_shift (
        .clk          (clk),
        .rst          (rst),
        .sample_i     (in),
        .valid_i      (in_valid),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // A release coinciding with a completion frees that block even when nothing else is held.
    always_comb begin
        release_blk = blk_ack && ((occ_q != 3'd0) || blk_done_q);
        occ_d       = occ_q;
        if (blk_done_q && !release_blk) begin
            occ_d = occ_q + 3'd1;
        end else if (!blk_done_q && release_blk) begin
            occ_d = occ_q - 3'd1;
        end
        full     = (occ_d == 3'd4);
        write_go = word_valid && !full;
        drop     = word_valid && full;
    end

    // The address register advances the cycle after each write, so it idles on the next free slot.
    always_comb begin
        addr_cur = sampleAddrIn_q;
        if (sampleWrite_q) begin
            addr_cur = (sampleAddrIn_q == ADDR_LAST) ? '0 : sampleAddrIn_q + 1'b1;
        end
        blk_end     = 1'b0;
        blk_end_idx = '0;
        for (int b = 0; b < NBLK; b++) begin
            if (addr_cur == AW'(b * DEPTH + DEPTH - 1)) begin
                blk_end     = 1'b1;
                blk_end_idx = 2'(b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sampleWrite_q  <= 1'b0;
            sampleAddrIn_q <= '0;
            sampleDataIn_q <= '0;
            blk_done_q     <= 1'b0;
            blk_idx_q      <= '0;
            ovf_q          <= 1'b0;
            occ_q          <= '0;
        end else begin
            sampleWrite_q  <= write_go;
            sampleAddrIn_q <= addr_cur;
            blk_done_q     <= write_go && blk_end;
            occ_q          <= occ_d;
            if (write_go) begin
                sampleDataIn_q <= word;
            end
            if (write_go && blk_end) begin
                blk_idx_q <= blk_end_idx;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef SAMPLE_PACKER_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

    assign sampleWrite  = sampleWrite_q;
    assign sampleAddrIn = sampleAddrIn_q;
    assign sampleDataIn = sampleDataIn_q;
    assign blk_done     = blk_done_q;
    assign blk_idx      = blk_idx_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_sample_packer.sv
// Randomised scoreboard bench for sample_packer; build with SAMPLE_PACKER_OVF_CNT_EN to cover ovf_cnt.
module tb_sample_packer;
    import sample_packer_pkg::*;

    localparam int N     = N_DEF;
    localparam int DSR   = DSR_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int W     = W_DEF;
    localparam int AW    = AW_DEF;
    localparam int NWORD = NBLK * DEPTH;

    logic          clk;
    logic          rst;
    logic [N-1:0]  smp;
    logic          in_valid;
    logic          blk_ack;
    logic          sampleWrite;
    logic [AW-1:0] sampleAddrIn;
    logic [W-1:0]  sampleDataIn;
    logic          blk_done;
    logic [1:0]    blk_idx;
    logic          ovf;
`ifdef SAMPLE_PACKER_OVF_CNT_EN
    logic [15:0]   ovf_cnt;
`endif

    sample_packer #(.N(N), .DSR(DSR), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (smp),
        .in_valid     (in_valid),
        .blk_ack      (blk_ack),
        .sampleWrite  (sampleWrite),
        .sampleAddrIn (sampleAddrIn),
        .sampleDataIn (sampleDataIn),
        .blk_done     (blk_done),
        .blk_idx      (blk_idx),
        .ovf          (ovf)
`ifdef SAMPLE_PACKER_OVF_CNT_EN
        ,
        .ovf_cnt      (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic          done;
        logic [1:0]    idx;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 0;

    // Reference model: pending samples, ring occupancy, next write address, overflow state.
    int  m_samp[$];
    int  m_occ = 0;
    int  m_addr = 0;
    int  m_cnt = 0;
    bit  m_ovf = 0;
    bit  exp_wr = 0;
    bit  exp_done = 0;
    logic [W-1:0] exp33;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input int s, input bit a);
        bit           rel;
        bit           nwr;
        bit           ndone;
        logic [W-1:0] w;
        wr_t          e;
        nwr   = 0;
        ndone = 0;
        if (r) begin
            m_samp.delete();
            m_occ  = 0;
            m_addr = 0;
            m_ovf  = 0;
            m_cnt  = 0;
        end else begin
            rel   = a && (m_occ > 0 || exp_done);
            m_occ = m_occ + int'(exp_done) - int'(rel);
            if (v) begin
                m_samp.push_back(s % (1 << N));
                if (m_samp.size() == DSR) begin
                    w = '0;
                    for (int k = 0; k < DSR; k++) w[k*N +: N] = N'(m_samp[k]);
                    m_samp.delete();
                    if (m_occ == NBLK) begin
                        m_ovf = 1;
                        if (m_cnt < 65535) m_cnt++;
                    end else begin
                        e.addr = AW'(m_addr);
                        e.data = w;
                        e.done = (m_addr % DEPTH) == DEPTH - 1;
                        e.idx  = 2'(m_addr / DEPTH);
                        sb.push_back(e);
                        nwr    = 1;
                        ndone  = e.done;
                        m_addr = (m_addr + 1) % NWORD;
                    end
                end
            end
        end
        exp_wr   = nwr;
        exp_done = ndone;
    endtask

    // Called at a falling edge: check the current cycle, drive the next one, advance the model.
    task automatic step(input bit r, input bit v, input int s, input bit a);
        chk("sampleWrite", 64'(sampleWrite), 64'(exp_wr));
        chk("blk_done", 64'(blk_done), 64'(exp_done));
        chk("ovf", 64'(ovf), 64'(m_ovf));
`ifdef SAMPLE_PACKER_OVF_CNT_EN
        chk("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
`endif
        rst      = r;
        in_valid = v;
        smp      = N'(s);
        blk_ack  = a;
        model_edge(r, v, s, a);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1, 1'($urandom), int'($urandom), 1'($urandom));
    endtask

    task automatic idle(input int n, input bit ack_done);
        repeat (n) step(0, 0, 0, ack_done & exp_done);
    endtask

    // mode 0: never ack; 1: ack coincident with blk_done; 2: ack the cycle after blk_done.
    task automatic stream(input int nw, input int mode);
        bit pend;
        bit a;
        pend = 0;
        for (int i = 0; i < nw * DSR; i++) begin
            a    = (mode == 1) ? exp_done : (mode == 2) ? pend : 1'b0;
            pend = exp_done;
            step(0, 1, int'($urandom), a);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && sampleWrite === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wr_unexpected: got write at addr %0d, expected no write", sampleAddrIn);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 64'(sampleAddrIn), 64'(mon_e.addr));
                chk("wr_data", 64'(sampleDataIn), 64'(mon_e.data));
                chk("wr_blk_done", 64'(blk_done), 64'(mon_e.done));
                if (mon_e.done) chk("wr_blk_idx", 64'(blk_idx), 64'(mon_e.idx));
            end
        end
    end

    initial begin
        exp33 = '0;
        for (int k = 0; k < DSR; k++) exp33[k*N +: N] = N'(k % 8);
        rst = 1; smp = '0; in_valid = 0; blk_ack = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1;
        chk("rst_sampleWrite", 64'(sampleWrite), 64'd0);
        chk("rst_addr", 64'(sampleAddrIn), 64'd0);
        chk("rst_data", 64'(sampleDataIn), 64'd0);
        chk("rst_blk_done", 64'(blk_done), 64'd0);
        chk("rst_blk_idx", 64'(blk_idx), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
`ifdef SAMPLE_PACKER_OVF_CNT_EN
        chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
        do_reset(3);

        // Continuous stream of 0..11 mod 8: one write at address 0, one cycle later.
        for (int i = 0; i < DSR; i++) step(0, 1, i % 8, 0);
        chk("cont_write_now", 64'(sampleWrite), 64'd1);
        chk("cont_addr", 64'(sampleAddrIn), 64'd0);
        chk("cont_data", 64'(sampleDataIn), 64'(exp33));
        idle(2, 0);

        // Alternating in_valid packs the same word.
        do_reset(1);
        for (int i = 0; i < 2 * DSR; i++) step(0, (i % 2) == 0, (i / 2) % 8, 0);
        idle(2, 0);

        // Full ring with every block released the cycle after completion.
        do_reset(1);
        stream(NWORD, 2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("ring_no_ovf", 64'(ovf), 64'd0);
        stream(1, 0);
        idle(2, 0);

        // No releases: the word after a full ring is dropped and the address holds.
        do_reset(1);
        stream(NWORD + 1, 0);
        idle(1, 0);
        chk("full_ovf", 64'(ovf), 64'd1);
`ifdef SAMPLE_PACKER_OVF_CNT_EN
        chk("full_ovf_cnt", 64'(ovf_cnt), 64'd1);
`endif
        step(0, 0, 0, 1);
        stream(1, 0);
        idle(2, 0);
        chk("ovf_sticky", 64'(ovf), 64'd1);

        // Release coincident with a completion keeps room for one more block.
        do_reset(1);
        stream(3 * DEPTH, 0);
        idle(2, 0);
        stream(DEPTH, 1);
        idle(2, 1);
        stream(DEPTH, 0);
        idle(2, 0);
        chk("coinc_no_ovf", 64'(ovf), 64'd0);
        stream(1, 0);
        idle(2, 0);
        chk("coinc_then_ovf", 64'(ovf), 64'd1);

        // Reset part-way through a word discards the partial samples.
        do_reset(1);
        for (int i = 0; i < 5; i++) step(0, 1, 7, 0);
        do_reset(1);
        for (int i = 0; i < DSR; i++) step(0, 1, i % 8, 0);
        chk("midrst_addr", 64'(sampleAddrIn), 64'd0);
        chk("midrst_data", 64'(sampleDataIn), 64'(exp33));
        idle(2, 0);

        // Random traffic, sparse releases, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 700) == 0, ($urandom % 10) < 7, int'($urandom), ($urandom % 12) == 0);
        end
        idle(4, 0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
